// File: rtl/midi_mem_arbiter_pkg.sv
// Shared definitions for the memory port-A arbiter and the MIDI note ring.
// Ring geometry lives here so every reader of the note ring agrees on it.
package midi_mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 16;

    localparam logic [MEM_ADDR_W-1:0] MIDI_RING_BASE = 14'h3F00;
    localparam int MIDI_RING_SLOTS = 16;

    localparam int MIDI_FIFO_DEPTH    = 4;
    localparam int STARVE_MAX_DEFAULT = 8;

    // Who owns port A in the cycle after arbitration.
    typedef enum logic [1:0] {
        PA_IDLE = 2'd0,
        PA_CPU  = 2'd1,
        PA_MIDI = 2'd2
    } porta_src_e;

endpackage

// File: rtl/midi_mem_arbiter_fifo.sv
// Small synchronous FIFO buffering captured MIDI notes ahead of the ring write.
// Head word is presented combinationally so the arbiter can register it on pop.
module midi_note_fifo
    import midi_mem_arbiter_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = MIDI_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/midi_mem_arbiter.sv
// Memory port-A arbiter: CPU has priority, buffered MIDI notes are forced in
// when the FIFO is full or the CPU has held the port for STARVE_MAX grants.
module midi_mem_arbiter
    import midi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W                 = MEM_ADDR_W,
    parameter int DATA_W                 = MEM_DATA_W,
    parameter int FIFO_DEPTH             = MIDI_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] MIDI_BASE = MIDI_RING_BASE,
    parameter int MIDI_SLOTS             = MIDI_RING_SLOTS,
    parameter int STARVE_MAX             = STARVE_MAX_DEFAULT,
    localparam int SLOT_W                = $clog2(MIDI_SLOTS),
    localparam int CNT_W                 = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_grant,
    output logic              o_cpu_rdata_valid,

    input  logic              i_midi_valid,
    input  logic [DATA_W-1:0] i_midi_note,
    output logic              o_midi_ready,

    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,

    output logic [SLOT_W-1:0] o_note_slot,
    output logic              o_note_written,
    output logic [CNT_W-1:0]  o_fifo_count,
    output logic              o_overflow,
    input  logic              i_overflow_clr
);

    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [DATA_W-1:0] w_fifo_head;

    logic              w_push;
    logic              w_drop;
    logic              w_starved;
    logic              w_midi_sel;
    logic              w_cpu_go;
    porta_src_e        w_src;

    logic [STV_W-1:0]  r_starve;
    logic [SLOT_W-1:0] r_slot;
    logic              r_ovf;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_note_written;
    logic              r_rd_pend;
    logic              r_rdata_valid;

    assign w_push     = i_midi_valid & ~w_fifo_full;
    assign w_drop     = i_midi_valid & w_fifo_full;
    assign w_starved  = (r_starve == STV_W'(STARVE_MAX));
    assign w_midi_sel = ~w_fifo_empty & (~i_cpu_req | w_fifo_full | w_starved);

    // Handshake outputs are held low while reset is asserted.
    assign w_cpu_go   = i_rst_n & i_cpu_req & ~w_midi_sel;

    midi_note_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_note_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (i_midi_note),
        .i_pop   (w_midi_sel),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_src = PA_IDLE;
        if (w_midi_sel) begin
            w_src = PA_MIDI;
        end else if (w_cpu_go) begin
            w_src = PA_CPU;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (w_fifo_empty || w_midi_sel) begin
            r_starve <= '0;
        end else if (w_cpu_go && !w_starved) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_overflow_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_note_written <= 1'b0;
            r_slot         <= '0;
            r_rd_pend      <= 1'b0;
            r_rdata_valid  <= 1'b0;
        end else begin
            r_note_written <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rdata_valid  <= r_rd_pend;
            case (w_src)
                PA_MIDI: begin
                    r_mem_en       <= 1'b1;
                    r_mem_we       <= 1'b1;
                    r_mem_addr     <= MIDI_BASE + ADDR_W'(r_slot);
                    r_mem_wdata    <= w_fifo_head;
                    r_note_written <= 1'b1;
                    r_slot         <= r_slot + SLOT_W'(1);
                end
                PA_CPU: begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= i_cpu_we;
                    r_mem_addr  <= i_cpu_addr;
                    r_mem_wdata <= i_cpu_wdata;
                    r_rd_pend   <= ~i_cpu_we;
                end
                default: begin
                    // Address and data hold so the memory pins stay quiet.
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_grant       = w_cpu_go;
    assign o_cpu_rdata_valid = r_rdata_valid;
    assign o_midi_ready      = i_rst_n & ~w_fifo_full;
    assign o_mem_en          = r_mem_en;
    assign o_mem_we          = r_mem_we;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_wdata       = r_mem_wdata;
    assign o_note_slot       = r_slot;
    assign o_note_written    = r_note_written;
    assign o_fifo_count      = w_fifo_count;
    assign o_overflow        = r_ovf;

endmodule

// File: doc/midi_mem_arbiter.md
Name: midi_mem_arbiter

Overview:
- Arbitrates memory port A between the CPU datapath (PC/register addressing, ALU write data) and the MIDI note capture path.
- MIDI notes are buffered in a small FIFO and written into a circular note buffer in data memory.
- CPU has priority, but MIDI is guaranteed service when its FIFO fills or after a starvation bound.
- Sits between the CPU address/data tri-state bus and the memory port-A inputs; replaces ad-hoc interrupt muxing.

Parameters:
- ADDR_W, 14, memory address width.
- DATA_W, 16, memory data width.
- FIFO_DEPTH, 4, MIDI note FIFO entries; must be a power of 2, ≥2.
- MIDI_BASE, 14'h3F00, first word of the note ring buffer.
- MIDI_SLOTS, 16, ring buffer length; must be a power of 2.
- STARVE_MAX, 8, maximum consecutive CPU grants while the FIFO is non-empty.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- cpu_req  in  1  CPU access request; fields held stable until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_grant  out  1  combinational; the transfer occurs in a cycle where cpu_req & cpu_grant
- cpu_rdata_valid  out  1  pulse; memory port-A read data is valid this cycle
- midi_valid  in  1  a new note is offered
- midi_note  in  DATA_W  note word
- midi_ready  out  1  equals !fifo_full
- mem_en  out  1  registered port-A enable
- mem_we  out  1  registered port-A write enable
- mem_addr  out  ADDR_W  registered port-A address
- mem_wdata  out  DATA_W  registered port-A write data
- note_slot  out  log2(MIDI_SLOTS)  next ring slot to be written
- note_written  out  1  pulse, aligned with the mem_en cycle of a MIDI write
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a note was dropped
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, the FIFO is empty, note_slot=0, the starvation counter is 0, and any in-flight read valid is cancelled. Reset may be asserted at any time; no partial write completes after it.
- FIFO: a push occurs when midi_valid & midi_ready. There is no push when full, even if a pop happens in the same cycle. Simultaneous push and pop leaves fifo_count unchanged. Data is first-in, first-out.
- overflow sets when midi_valid & !midi_ready, and the note is dropped. overflow_clr clears it. If set and clear occur in the same cycle, set wins.
- Arbitration, evaluated each cycle:
  - midi_sel = fifo_nonempty & (!cpu_req | fifo_full | starve_cnt == STARVE_MAX).
  - cpu_grant = cpu_req & !midi_sel.
- Starvation counter:
  - Increments on each CPU grant while the FIFO is non-empty, saturating at STARVE_MAX.
  - Clears on a MIDI selection or when the FIFO is empty.
- Cycle N, CPU granted. In N+1: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - For a read, cpu_rdata_valid=1 in N+2, because the memory has one-cycle synchronous read latency.
  - Back-to-back grants give one access per cycle.
- Cycle N, midi_sel: the FIFO pops. In N+1: mem_en=1, mem_we=1, mem_addr=MIDI_BASE+note_slot, mem_wdata=head note, note_written=1.
  - note_slot increments in N+1 and wraps from MIDI_SLOTS-1 to 0. The ring silently overwrites old notes.
- Idle cycles (no grant, no midi_sel): mem_en=0 and mem_we=0 next cycle. mem_addr and mem_wdata hold their last values.
- CPU accesses to ring addresses are not blocked. Software owns consistency.
- Maximum CPU wait while requesting: 1 cycle per pending note, at most FIFO_DEPTH consecutive cycles.

Decomposition:
- Shared package holds:
  - MEM_ADDR_W and MEM_DATA_W.
  - MIDI_RING_BASE and MIDI_RING_SLOTS, so the VGA and note-scoring logic read the same ring.
  - The default STARVE_MAX.
- One sub-module: midi_note_fifo (synchronous FIFO with count, full, empty; same clk and asynchronous active-low reset).
- Arbitration, counters and port-A output registers stay in the top module.

Test Plan:
- Reset, then a CPU write: addr 14'h0010, data 16'hBEEF → cpu_grant same cycle; next cycle mem_en=1, mem_we=1, addr 0x0010, data 0xBEEF; no cpu_rdata_valid.
- CPU read of 0x0020 → mem_en=1, mem_we=0 at N+1; cpu_rdata_valid=1 at N+2 only.
- CPU idle, push notes 0x0045 then 0x0047 → writes to 0x3F00, then 0x3F01; note_written pulses twice; note_slot=2; fifo_count returns to 0.
- CPU requests continuously, one note pushed → note written after exactly 8 CPU grants (STARVE_MAX). cpu_grant is low for 1 cycle only.
- FIFO full under a continuous CPU request, plus a fifth note offered → midi_ready=0 and overflow=1. The MIDI path then wins the next arbitration cycle. overflow_clr together with a new drop in the same cycle keeps overflow=1.
- 17 notes with the CPU idle → the 17th goes to 0x3F00 (wrap). Async reset asserted mid-read → cpu_rdata_valid stays 0 and all outputs go to 0 immediately.
